// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - coordinate/control inputs and pixel outputs of the test-pattern source
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 8
);
    logic [9:0]         pixel_x;
    logic [9:0]         pixel_y;
    logic [1:0]         mode_sel;
    logic               pause;
    logic               step_dir;
    logic [COLOR_W-1:0] color_out;
    logic               frame_tick;
    logic [15:0]        frame_count;

    modport master (
        output pixel_x, pixel_y, mode_sel, pause, step_dir,
        input  color_out, frame_tick, frame_count
    );

    modport slave (
        input  pixel_x, pixel_y, mode_sel, pause, step_dir,
        output color_out, frame_tick, frame_count
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - multi-mode VGA test-pattern source with frame divider and frame tick
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COLOR_W    = 8,
    parameter int FRAME_DIV  = 1,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5
) (
    input logic              clk,
    input logic              rst_n,
    vga_pattern_gen_if.slave bus
);
    localparam int BAR_STEP = (1 << COLOR_W) / NUM_BARS;

    logic               eof;
    logic               eof_q;
    logic               eof_rise;
    logic               in_range;
    logic               check_sel;
    logic [COLOR_W-1:0] bar_col;
    logic [COLOR_W-1:0] grad_col;
    logic [COLOR_W-1:0] pattern;
    logic [COLOR_W-1:0] phase;
    logic [COLOR_W-1:0] color_q;
    logic [15:0]        div_cnt;
    logic [15:0]        count_q;
    logic [1:0]         mode_q;
    logic               tick_q;

    assign eof      = (bus.pixel_x == 10'(H_ACTIVE - 1)) && (bus.pixel_y == 10'(V_ACTIVE - 1));
    assign eof_rise = eof && !eof_q;
    assign in_range = ({1'b0, bus.pixel_x} < 11'(H_ACTIVE)) && ({1'b0, bus.pixel_y} < 11'(V_ACTIVE));

    // Bar index is a divide by a constant, so it folds into fixed logic.
    assign bar_col   = COLOR_W'(((32'(bus.pixel_x) * NUM_BARS) / H_ACTIVE) * BAR_STEP);
    assign grad_col  = COLOR_W'(bus.pixel_x) + COLOR_W'(bus.pixel_y);
    assign check_sel = bus.pixel_x[CHECK_LOG2] ^ bus.pixel_y[CHECK_LOG2];

    // Pattern selection uses the per-frame mode shadow so a live mode change never tears a frame.
    always_comb begin
        pattern = '0;
        if (in_range) begin
            case (mode_q)
                2'd0:    pattern = phase;
                2'd1:    pattern = phase + bar_col;
                2'd2:    pattern = check_sel ? ~phase : phase;
                default: pattern = grad_col + phase;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eof_q   <= 1'b0;
            tick_q  <= 1'b0;
            color_q <= '0;
            count_q <= '0;
            mode_q  <= '0;
            phase   <= '0;
            div_cnt <= '0;
        end else begin
            eof_q   <= eof;
            tick_q  <= eof_rise;
            color_q <= pattern;
            if (eof_rise) begin
                count_q <= count_q + 16'd1;
                mode_q  <= bus.mode_sel;
                if (!bus.pause) begin
                    if (div_cnt == 16'(FRAME_DIV - 1)) begin
                        div_cnt <= '0;
                        phase   <= bus.step_dir ? phase - COLOR_W'(1) : phase + COLOR_W'(1);
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.color_out   = color_q;
    assign bus.frame_tick  = tick_q;
    assign bus.frame_count = count_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - randomized model-checked bench for vga_pattern_gen
module tb_vga_pattern_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] px = '0;
    logic [9:0] py = '0;
    logic [1:0] mode_sel = '0;
    logic       pause = 1'b0;
    logic       step_dir = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    vga_pattern_gen_if #(.COLOR_W(8)) bus1 ();
    vga_pattern_gen_if #(.COLOR_W(8)) bus4 ();

    assign bus1.pixel_x  = px;
    assign bus1.pixel_y  = py;
    assign bus1.mode_sel = mode_sel;
    assign bus1.pause    = pause;
    assign bus1.step_dir = step_dir;
    assign bus4.pixel_x  = px;
    assign bus4.pixel_y  = py;
    assign bus4.mode_sel = mode_sel;
    assign bus4.pause    = pause;
    assign bus4.step_dir = step_dir;

    vga_pattern_gen #(.FRAME_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    vga_pattern_gen #(.FRAME_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    always #20 clk = ~clk;

    // Reference state: phases as plain integers, the divide-by-4 path as a count of unpaused frames.
    int m_phase1 = 0;
    int m_phase4 = 0;
    int m_unpaused = 0;
    int m_mode = 0;
    int m_count = 0;
    int m_prev_eof = 0;
    int e_color1 = 0;
    int e_color4 = 0;
    int e_tick = 0;

    function automatic int exp_color(int x, int y, int mode, int ph);
        if (x >= 640 || y >= 480) return 0;
        case (mode)
            0: return ph;
            1: return (ph + ((x * 8) / 640) * 32) % 256;
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 255 - ph : ph;
            default: return ((x % 256) + (y % 256) + ph) % 256;
        endcase
    endfunction

    initial begin : model
        int eof_now;
        int delta;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase1 = 0; m_phase4 = 0; m_unpaused = 0; m_mode = 0;
                m_count = 0; m_prev_eof = 0; e_color1 = 0; e_color4 = 0; e_tick = 0;
            end else begin
                e_color1 = exp_color(int'(px), int'(py), m_mode, m_phase1);
                e_color4 = exp_color(int'(px), int'(py), m_mode, m_phase4);
                eof_now  = (px == 10'd639 && py == 10'd479) ? 1 : 0;
                e_tick   = (eof_now == 1 && m_prev_eof == 0) ? 1 : 0;
                m_prev_eof = eof_now;
                if (e_tick == 1) begin
                    m_count = (m_count + 1) % 65536;
                    m_mode  = int'(mode_sel);
                    if (!pause) begin
                        delta = step_dir ? 255 : 1;
                        m_phase1 = (m_phase1 + delta) % 256;
                        m_unpaused++;
                        if (m_unpaused % 4 == 0) m_phase4 = (m_phase4 + delta) % 256;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            check("color_div1", int'(bus1.color_out), e_color1);
            check("color_div4", int'(bus4.color_out), e_color4);
            check("tick_div1", int'(bus1.frame_tick), e_tick);
            check("tick_div4", int'(bus4.frame_tick), e_tick);
            check("count_div1", int'(bus1.frame_count), m_count);
            check("count_div4", int'(bus4.frame_count), m_count);
        end
    end

    initial begin : watchdog
        #(40 * 60000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic pix(input int x, input int y);
        @(negedge clk);
        px = 10'(x);
        py = 10'(y);
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_pix(input int oor);
        int x;
        int y;
        x = oor ? $urandom_range(0, 703) : $urandom_range(0, 639);
        y = oor ? $urandom_range(0, 511) : $urandom_range(0, 479);
        if (x == 639 && y == 479) x = 0;
        pix(x, y);
    endtask

    task automatic run_frame(input int n);
        repeat (n) rand_pix(0);
        pix(639, 479);
    endtask

    initial begin : stimulus
        int ticks;
        int xs [4];
        int es [4];
        xs = '{0, 79, 80, 639};
        es = '{8'h00, 8'h00, 8'h20, 8'hE0};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pix(0, 0);
        sample();
        check("reset_color", int'(bus1.color_out), 0);
        check("reset_tick", int'(bus1.frame_tick), 0);
        check("reset_count", int'(bus1.frame_count), 0);

        repeat (3) run_frame(15);
        pix(0, 0);
        sample();
        check("solid_inc_color", int'(bus1.color_out), 8'h03);
        check("solid_inc_count", int'(bus1.frame_count), 3);
        check("model_phase_inc", m_phase1, 3);

        do_reset();
        step_dir = 1'b1;
        repeat (3) run_frame(15);
        pix(0, 0);
        sample();
        check("solid_dec_color", int'(bus1.color_out), 8'hFD);
        step_dir = 1'b0;

        do_reset();
        for (int f = 1; f <= 8; f++) begin
            pause = (f == 2 || f == 3);
            run_frame(10);
        end
        pause = 1'b0;
        pix(0, 0);
        sample();
        check("div4_count", int'(bus4.frame_count), 8);
        check("div4_color", int'(bus4.color_out), 8'h01);
        check("model_phase_div4", m_phase4, 1);
        check("div1_paused_color", int'(bus1.color_out), 8'h06);

        do_reset();
        mode_sel = 2'd1;
        pause = 1'b1;
        run_frame(5);
        pix(0, 0);
        pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix(xs[i], 0);
            if (xs[i] == 80) check("bar_latency", int'(bus1.color_out), 8'h00);
            sample();
            check("bar_color", int'(bus1.color_out), es[i]);
        end

        do_reset();
        mode_sel = 2'd0;
        pause = 1'b1;
        pix(10, 10);
        pix(300, 200);
        mode_sel = 2'd2;
        sample();
        check("no_tear_300_200", int'(bus1.color_out), 8'h00);
        pix(32, 0);
        sample();
        check("no_tear_32_0", int'(bus1.color_out), 8'h00);
        pix(639, 479);
        pix(0, 0);
        sample();
        check("checker_0_0", int'(bus1.color_out), 8'h00);
        pix(32, 0);
        sample();
        check("checker_32_0", int'(bus1.color_out), 8'hFF);
        pix(32, 32);
        sample();
        check("checker_32_32", int'(bus1.color_out), 8'h00);

        do_reset();
        mode_sel = 2'd3;
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            pix(639, 479);
            sample();
            ticks += int'(bus1.frame_tick);
        end
        check("eof_hold_ticks", ticks, 1);
        check("eof_hold_count", int'(bus1.frame_count), 1);
        pix(700, 10);
        sample();
        check("blank_x700", int'(bus1.color_out), 0);
        pix(10, 20);
        sample();
        check("gradient_10_20", int'(bus1.color_out), 8'h1E);
        pix(100, 100);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_color", int'(bus1.color_out), 0);
        check("async_rst_count", int'(bus1.frame_count), 0);
        check("async_rst_tick", int'(bus1.frame_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pause = 1'b0;
        pix(639, 479);
        sample();
        check("post_rst_tick", int'(bus1.frame_tick), 1);
        check("post_rst_count", int'(bus1.frame_count), 1);
        pix(0, 0);

        for (int f = 0; f < 30; f++) begin
            int n;
            mode_sel = 2'($urandom_range(0, 3));
            pause    = ($urandom_range(0, 3) == 0);
            step_dir = 1'($urandom_range(0, 1));
            n = $urandom_range(10, 60);
            for (int i = 0; i < n; i++) begin
                rand_pix($urandom_range(0, 9) == 0 ? 1 : 0);
                if ($urandom_range(0, 15) == 0) mode_sel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) pause = ~pause;
            end
            repeat ($urandom_range(1, 4)) pix(639, 479);
        end
        pix(0, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
